// File: rtl/cyclic_code_pkg.sv
// Shared constants and state encoding for the serial (7,4) cyclic encoder path.
// Generator x^3+x+1; codeword is 4 info bits followed by 3 parity bits, MSB first.
package cyclic_code_pkg;

    localparam int CC_N = 7;
    localparam int CC_K = 4;
    localparam int CC_R = 3;

    localparam logic [CC_R:0] CC_GEN = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        GAP
    } cc_state_t;

endpackage

// File: rtl/cyclic_parity_lfsr.sv
// Parity remainder register for g(x)=x^3+x+1: divide on shift-in, drain MSB-first on shift-out.
// Latency: one clock per shift; clear has priority over both shift modes.
// Backpressure: none internally, the controller only enables a shift on an accepted bit.
module cyclic_parity_lfsr
    import cyclic_code_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            shift_in_en,
    input  logic            shift_out_en,
    input  logic            din,
    output logic            msb,
    output logic [CC_R-1:0] rem
);

    logic [CC_R-1:0] r;
    logic            fb;

    assign fb  = din ^ r[CC_R-1];
    assign msb = r[CC_R-1];
    assign rem = r;

    // Feedback taps come straight from the low generator coefficients.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r <= '0;
        end else if (clear) begin
            r <= '0;
        end else if (shift_in_en) begin
            r <= {r[CC_R-2:0], 1'b0} ^ ({CC_R{fb}} & CC_GEN[CC_R-1:0]);
        end else if (shift_out_en) begin
            r <= {r[CC_R-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/cyclic_coder_ctrl.sv
// Bit-serial (7,4) systematic cyclic encoder controller: word in, 7 bits out with sof/eof.
// Latency: first bit one cycle after the input handshake; 8 + GAP_CYCLES cycles minimum per word.
// Backpressure: per-bit out_ready stall holds all outputs; in_ready only in IDLE.
module cyclic_coder_ctrl
    import cyclic_code_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [CC_K-1:0]    in_data,
    output logic               in_ready,
    output logic               out_bit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eof,
    output logic               busy,
    output logic [COUNT_W-1:0] cw_count
);

    localparam logic [2:0] LAST_INFO = 3'(CC_K - 1);
    localparam logic [2:0] LAST_BIT  = 3'(CC_N - 1);
    localparam logic [3:0] GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    cc_state_t         state;
    cc_state_t         state_nxt;
    logic [2:0]        bit_cnt;
    logic [3:0]        gap_cnt;
    logic [CC_K-1:0]   word;
    logic [1:0]        data_idx;
    logic              xfer;
    logic              accept;
    logic              lfsr_clear;
    logic              lfsr_shift_in;
    logic              lfsr_shift_out;
    logic              lfsr_msb;
    logic [CC_R-1:0]   parity_rem_unused;

    assign xfer     = out_valid & out_ready;
    assign accept   = in_valid & in_ready & ~abort;
    assign data_idx = 2'd3 - bit_cnt[1:0];
    assign busy     = (state != IDLE);

    cyclic_parity_lfsr u_lfsr (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (lfsr_clear),
        .shift_in_en  (lfsr_shift_in),
        .shift_out_en (lfsr_shift_out),
        .din          (out_bit),
        .msb          (lfsr_msb),
        .rem          (parity_rem_unused)
    );

    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        out_bit        = 1'b0;
        out_sof        = 1'b0;
        out_eof        = 1'b0;
        lfsr_clear     = 1'b0;
        lfsr_shift_in  = 1'b0;
        lfsr_shift_out = 1'b0;

        case (state)
            IDLE: begin
                in_ready   = 1'b1;
                lfsr_clear = 1'b1;
                if (accept) state_nxt = DATA;
            end
            DATA: begin
                out_valid     = 1'b1;
                out_bit       = word[data_idx];
                out_sof       = (bit_cnt == 3'd0);
                lfsr_shift_in = xfer;
                if (xfer && bit_cnt == LAST_INFO) state_nxt = PARITY;
            end
            PARITY: begin
                out_valid      = 1'b1;
                out_bit        = lfsr_msb;
                out_eof        = (bit_cnt == LAST_BIT);
                lfsr_shift_out = xfer;
                if (xfer && bit_cnt == LAST_BIT) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A bit transferring alongside abort is dropped; the remainder must not see it.
        if (abort) begin
            state_nxt  = IDLE;
            lfsr_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            word     <= '0;
            cw_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word    <= in_data;
                bit_cnt <= '0;
            end else if (xfer) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (xfer && state == PARITY && bit_cnt == LAST_BIT && !abort) begin
                cw_count <= cw_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: doc/cyclic_coder_ctrl.md
# cyclic_coder_ctrl

Sequencing controller for the serial (7,4) cyclic encoder path. It accepts 4-bit data words over a valid/ready handshake and emits each one as a 7-bit systematic codeword, MSB first, on a bit-serial stream with per-bit backpressure. The stream carries the 4 information bits followed by 3 parity bits, with start/end-of-codeword markers. It sits between the word-level source and the serial line/modulator, and owns the parity LFSR's clear, shift-in and shift-out sequencing.

## Interface
- GAP_CYCLES, default 0: idle cycles forced after each codeword's last bit (0..15).
- COUNT_W, default 16: width of the completed-codeword counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous; drops the current codeword, returns to IDLE.
- in_valid  in  1  in_data is valid.
- in_data  in  4  information word, bit 3 sent first.
- in_ready  out  1  controller can accept a word.
- out_bit  out  1  serial codeword bit.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  sink accepts out_bit.
- out_sof  out  1  out_bit is codeword bit 0 (first info bit).
- out_eof  out  1  out_bit is codeword bit 6 (last parity bit).
- busy  out  1  state != IDLE.
- cw_count  out  COUNT_W  completed codewords, wraps modulo 2^COUNT_W.

## Operation
- Code: generator g(x)=x^3+x+1. Codeword = d3 d2 d1 d0 p2 p1 p0, where p = (d·x^3) mod g.
- LFSR r[2:0]:
  - Shift-in: f=d^r[2]; r2<=r1; r1<=r0^f; r0<=f.
  - Shift-out: r2<=r1; r1<=r0; r0<=0.
- States:
  - IDLE: in_ready=1, r cleared. Handshake (in_valid&in_ready) latches in_data and bit_cnt=0, then goes to DATA.
  - DATA: out_bit=word[3-bit_cnt]. Each transfer (out_valid&out_ready) shifts that bit into the LFSR and increments bit_cnt. The transfer at bit_cnt=3 goes to PARITY.
  - PARITY: out_bit=r[2]. Each transfer does shift-out and increments bit_cnt. The transfer at bit_cnt=6 increments cw_count, then goes to GAP (GAP_CYCLES>0) or IDLE.
  - GAP: counts GAP_CYCLES clocks, then goes to IDLE. out_valid=0 and in_ready=0.
- Markers:
  - out_valid=1 in DATA and PARITY only.
  - out_sof=1 only in DATA with bit_cnt=0.
  - out_eof=1 only in PARITY with bit_cnt=6.
- out_bit, out_sof and out_eof are held stable while out_valid&!out_ready.
- abort (any state):
  - Next state IDLE, LFSR cleared, cw_count unchanged.
  - No eof is emitted. A bit transferring in the same cycle is considered lost.
  - In IDLE, abort overrides a concurrent input handshake: the word is not accepted.
- cw_count: 0xFFFF + 1 -> 0 at COUNT_W=16.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - state=IDLE, so in_ready=1 and busy=0.
  - out_valid=0, out_bit=0, out_sof=0, out_eof=0.
  - cw_count=0, LFSR=0.
- Latency: handshake at edge N gives first bit valid in cycle N+1 (out_sof=1).
- With out_ready held at 1, bits appear in cycles N+1..N+7 and IDLE is re-entered at N+8 (GAP=0).
- Minimum 8 cycles per codeword with GAP_CYCLES=0, 8+GAP_CYCLES otherwise.
- in_ready is combinational from state only, with no dependence on in_valid.
- out_valid has no dependence on out_ready.
- Stalls of any length are legal. The LFSR only changes on transfers.
- Reset asserted mid-codeword: outputs go to reset values immediately. After release the block is in IDLE with no residual state.

## Structure
- Package cyclic_code_pkg holds:
  - CC_N=7, CC_K=4, CC_R=3.
  - CC_GEN=4'b1011.
  - state enum cc_state_t {IDLE, DATA, PARITY, GAP}.
- Sub-module cyclic_parity_lfsr:
  - Ports: clk, reset_n, clear, shift_in_en, shift_out_en, din, msb, rem[2:0].
  - Behaviour: implements both shift modes; clear has priority.
- The controller holds the FSM, bit_cnt (3 bits), gap counter (4 bits), word register and cw_count.

## Test plan
- Word 4'b1000, out_ready=1 -> serial 1,0,0,0,1,0,1. sof on bit 1, eof on bit 7, cw_count=1.
- Words 4'b0001 then 4'b1111, back-to-back in_valid -> 0001011, then 1111111. Second word accepted 8 cycles after the first.
- Word 4'b1000 with out_ready low for 3 cycles at bit 2 and at bit 6 -> identical bit sequence, outputs held during stalls, total latency +6.
- abort asserted during PARITY bit 5 -> IDLE next cycle, no eof, cw_count unchanged. Next word 4'b0001 -> 0001011 (LFSR clean).
- GAP_CYCLES=3 -> in_ready low for 3 cycles after eof. cw_count preset near 0xFFFF wraps to 0.
- reset_n pulsed low mid-DATA -> all outputs at reset values asynchronously, in_ready=1 after release.
